// File: rtl/mem_arb.sv
// Two-requester (fetch/data) arbiter onto one registered memory port. One transaction in flight; grant->rsp pulse is 3 cycles minimum.
// Backpressure: requester ready only in IDLE for the granted side; m_* payload held until m_req_ready_i; fetch flush drops its response.
module mem_arb #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid_i,
  output logic              i_req_ready_o,
  input  logic [XLEN-1:0]   i_addr_i,
  input  logic              i_flush_i,
  output logic              i_rsp_valid_o,
  output logic [XLEN-1:0]   i_rsp_data_o,
  input  logic              d_req_valid_i,
  output logic              d_req_ready_o,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic [XLEN-1:0]   d_wdata_i,
  input  logic              d_we_i,
  input  logic [XLEN/8-1:0] d_wstrb_i,
  output logic              d_rsp_valid_o,
  output logic [XLEN-1:0]   d_rsp_data_o,
  output logic              m_req_valid_o,
  input  logic              m_req_ready_i,
  output logic [XLEN-1:0]   m_addr_o,
  output logic [XLEN-1:0]   m_wdata_o,
  output logic              m_we_o,
  output logic [XLEN/8-1:0] m_wstrb_o,
  input  logic              m_rsp_valid_i,
  input  logic [XLEN-1:0]   m_rsp_data_i
);

  localparam int SW = XLEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            we;
    logic [SW-1:0]   wstrb;
  } mreq_t;

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  owner_t          last_q, last_d;
  logic            discard_q, discard_d;
  logic            m_vld_q, m_vld_d;
  mreq_t           m_req_q, m_req_d;
  logic            i_rsp_vld_q, i_rsp_vld_d;
  logic [XLEN-1:0] i_rsp_dat_q, i_rsp_dat_d;
  logic            d_rsp_vld_q, d_rsp_vld_d;
  logic [XLEN-1:0] d_rsp_dat_q, d_rsp_dat_d;
  logic            grant_i, grant_d;
  logic            fetch_flush;

  assign fetch_flush = i_flush_i && (owner_q == OWN_I);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    discard_d   = discard_q;
    m_vld_d     = m_vld_q;
    m_req_d     = m_req_q;
    i_rsp_vld_d = 1'b0;
    i_rsp_dat_d = i_rsp_dat_q;
    d_rsp_vld_d = 1'b0;
    d_rsp_dat_d = d_rsp_dat_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the side that lost last time wins.
        grant_d   = d_req_valid_i && (!i_req_valid_i || (last_q == OWN_I));
        grant_i   = i_req_valid_i && !grant_d;
        discard_d = 1'b0;
        if (grant_d) begin
          m_req_d = '{addr: d_addr_i, wdata: d_wdata_i, we: d_we_i, wstrb: d_wstrb_i};
          owner_d = OWN_D;
          last_d  = OWN_D;
          m_vld_d = 1'b1;
          state_d = REQ;
        end else if (grant_i) begin
          m_req_d = '{addr: i_addr_i, wdata: '0, we: 1'b0, wstrb: '0};
          owner_d = OWN_I;
          last_d  = OWN_I;
          m_vld_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (fetch_flush) discard_d = 1'b1;
        if (m_req_ready_i) begin
          m_vld_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (m_rsp_valid_i) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          if (owner_q == OWN_D) begin
            d_rsp_vld_d = 1'b1;
            d_rsp_dat_d = m_rsp_data_i;
          end else if (!discard_q && !i_flush_i) begin
            i_rsp_vld_d = 1'b1;
            i_rsp_dat_d = m_rsp_data_i;
          end
        end else if (fetch_flush) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      last_q      <= OWN_I;
      discard_q   <= 1'b0;
      m_vld_q     <= 1'b0;
      m_req_q     <= '0;
      i_rsp_vld_q <= 1'b0;
      i_rsp_dat_q <= '0;
      d_rsp_vld_q <= 1'b0;
      d_rsp_dat_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      discard_q   <= discard_d;
      m_vld_q     <= m_vld_d;
      m_req_q     <= m_req_d;
      i_rsp_vld_q <= i_rsp_vld_d;
      i_rsp_dat_q <= i_rsp_dat_d;
      d_rsp_vld_q <= d_rsp_vld_d;
      d_rsp_dat_q <= d_rsp_dat_d;
    end
  end

  assign i_req_ready_o = grant_i;
  assign d_req_ready_o = grant_d;
  assign m_req_valid_o = m_vld_q;
  assign m_addr_o      = m_req_q.addr;
  assign m_wdata_o     = m_req_q.wdata;
  assign m_we_o        = m_req_q.we;
  assign m_wstrb_o     = m_req_q.wstrb;
  assign i_rsp_valid_o = i_rsp_vld_q;
  assign i_rsp_data_o  = i_rsp_dat_q;
  assign d_rsp_valid_o = d_rsp_vld_q;
  assign d_rsp_data_o  = d_rsp_dat_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: arbitration order, latency, stalls, flush discard, spurious responses, reset.
module tb_mem_arb;

  logic        clk;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_flush, i_rsp_valid;
  logic [31:0] i_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_we, d_rsp_valid;
  logic [31:0] d_addr, d_wdata, d_rsp_data;
  logic [3:0]  d_wstrb;
  logic        m_req_valid, m_req_ready, m_we, m_rsp_valid;
  logic [31:0] m_addr, m_wdata, m_rsp_data;
  logic [3:0]  m_wstrb;

  int n_checks = 0;
  int n_errors = 0;

  mem_arb #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid_i(i_req_valid), .i_req_ready_o(i_req_ready), .i_addr_i(i_addr),
    .i_flush_i(i_flush), .i_rsp_valid_o(i_rsp_valid), .i_rsp_data_o(i_rsp_data),
    .d_req_valid_i(d_req_valid), .d_req_ready_o(d_req_ready), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_we_i(d_we), .d_wstrb_i(d_wstrb),
    .d_rsp_valid_o(d_rsp_valid), .d_rsp_data_o(d_rsp_data),
    .m_req_valid_o(m_req_valid), .m_req_ready_i(m_req_ready), .m_addr_o(m_addr),
    .m_wdata_o(m_wdata), .m_we_o(m_we), .m_wstrb_o(m_wstrb),
    .m_rsp_valid_i(m_rsp_valid), .m_rsp_data_i(m_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mvld"},  {31'b0, m_req_valid}, 32'd0);
    check({tag, "_maddr"}, m_addr, 32'd0);
    check({tag, "_mwdat"}, m_wdata, 32'd0);
    check({tag, "_mwe"},   {31'b0, m_we}, 32'd0);
    check({tag, "_mstrb"}, {28'b0, m_wstrb}, 32'd0);
    check({tag, "_rsp"},   {30'b0, i_rsp_valid, d_rsp_valid}, 32'd0);
    check({tag, "_irdat"}, i_rsp_data, 32'd0);
    check({tag, "_drdat"}, d_rsp_data, 32'd0);
  endtask

  // Starts in an IDLE cycle at posedge+1 and ends in an IDLE cycle at posedge+1.
  // flush_at: 0 none, 1 during REQ, 2 in WAIT before the response, 3 with the response.
  task automatic run_xact(input string tag, input bit dside, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] rdata,
                          input int stall, input int flush_at);
    bit exp_i;
    exp_i = !dside && (flush_at == 0);
    if (dside) begin
      d_req_valid = 1'b1; d_addr = addr; d_wdata = wdata; d_we = we; d_wstrb = strb;
    end else begin
      i_req_valid = 1'b1; i_addr = addr;
    end
    #1;
    check({tag, "_rdy"}, {30'b0, i_req_ready, d_req_ready}, dside ? 32'd1 : 32'd2);
    tick();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    for (int k = 0; k <= stall; k++) begin
      check({tag, "_mvld"},  {31'b0, m_req_valid}, 32'd1);
      check({tag, "_maddr"}, m_addr, addr);
      check({tag, "_mwe"},   {31'b0, m_we}, dside ? {31'b0, we} : 32'd0);
      check({tag, "_mstrb"}, {28'b0, m_wstrb}, dside ? {28'b0, strb} : 32'd0);
      if (dside) check({tag, "_mwdat"}, m_wdata, wdata);
      m_req_ready = (k == stall);
      i_flush = (k == stall) && (flush_at == 1);
      tick();
    end
    m_req_ready = 1'b0;
    i_flush = 1'b0;
    check({tag, "_mvld_off"}, {31'b0, m_req_valid}, 32'd0);
    if (flush_at == 2) begin
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
    end
    m_rsp_valid = 1'b1;
    m_rsp_data = rdata;
    i_flush = (flush_at == 3);
    tick();
    m_rsp_valid = 1'b0;
    i_flush = 1'b0;
    check({tag, "_pulse"}, {30'b0, i_rsp_valid, d_rsp_valid},
          dside ? 32'd1 : (exp_i ? 32'd2 : 32'd0));
    if (exp_i) check({tag, "_irdat"}, i_rsp_data, rdata);
    if (dside && !we) check({tag, "_drdat"}, d_rsp_data, rdata);
    tick();
    check({tag, "_pulse_end"}, {30'b0, i_rsp_valid, d_rsp_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_req_valid = 0; i_addr = 0; i_flush = 0;
    d_req_valid = 0; d_addr = 0; d_wdata = 0; d_we = 0; d_wstrb = 0;
    m_req_ready = 0; m_rsp_valid = 0; m_rsp_data = 0;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;

    // Both requesters held valid: D, I, D, I with back-to-back grants.
    i_req_valid = 1'b1; i_addr = 32'hA0;
    d_req_valid = 1'b1; d_addr = 32'hB0; d_we = 1'b0;
    for (int r = 0; r < 4; r++) begin
      #1;
      check("arb_rdy", {30'b0, i_req_ready, d_req_ready}, (r % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      check("arb_addr", m_addr, (r % 2 == 0) ? 32'hB0 : 32'hA0);
      m_req_ready = 1'b1;
      tick();
      m_req_ready = 1'b0;
      m_rsp_valid = 1'b1;
      m_rsp_data = r;
      tick();
      m_rsp_valid = 1'b0;
      check("arb_rsp", {30'b0, i_rsp_valid, d_rsp_valid}, (r % 2 == 0) ? 32'd1 : 32'd2);
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;

    run_xact("fetch",   1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0);
    run_xact("dwrite",  1'b1, 1'b1, 32'h200, 32'h12345678, 4'hF, 32'h0, 3, 0);
    run_xact("dflush",  1'b1, 1'b0, 32'h204, 32'h0, 4'h0, 32'hCAFEF00D, 0, 1);
    run_xact("fl_wait", 1'b0, 1'b0, 32'h180, 32'h0, 4'h0, 32'h11111111, 0, 2);
    run_xact("fetch2",  1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 32'h0BADC0DE, 0, 0);
    run_xact("fl_same", 1'b0, 1'b0, 32'h184, 32'h0, 4'h0, 32'h22222222, 0, 3);
    run_xact("fl_req",  1'b0, 1'b0, 32'h188, 32'h0, 4'h0, 32'h33333333, 1, 1);

    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    run_xact("fl_idle", 1'b0, 1'b0, 32'h308, 32'h0, 4'h0, 32'h44444444, 0, 0);

    m_rsp_valid = 1'b1;
    m_rsp_data = 32'h55555555;
    tick();
    m_rsp_valid = 1'b0;
    check("spur_pulse", {30'b0, i_rsp_valid, d_rsp_valid}, 32'd0);
    check("spur_mvld", {31'b0, m_req_valid}, 32'd0);
    tick();
    check("spur_pulse2", {30'b0, i_rsp_valid, d_rsp_valid}, 32'd0);

    // Reset while a fetch waits for its response.
    i_req_valid = 1'b1; i_addr = 32'h400;
    tick();
    i_req_valid = 1'b0;
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_wait");
    m_rsp_valid = 1'b1;
    m_rsp_data = 32'h66666666;
    tick();
    m_rsp_valid = 1'b0;
    check_reset_state("post_rst");
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    #1;
    check("post_rst_tie", {30'b0, i_req_ready, d_req_ready}, 32'd1);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
